// File: rtl/axi_lite_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_rd_arbiter
// Brief    : Two-master (IFU/LSU) to one-slave AXI-lite read arbiter with
//            round-robin grant and a single outstanding transaction.
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          m_arvalid,
    output logic [1:0]          m_arready,
    input  logic [2*ADDR_W-1:0] m_araddr,
    output logic [1:0]          m_rvalid,
    input  logic [1:0]          m_rready,
    output logic [2*DATA_W-1:0] m_rdata,
    output logic [3:0]          m_rresp,
    output logic                s_arvalid,
    input  logic                s_arready,
    output logic [ADDR_W-1:0]   s_araddr,
    input  logic                s_rvalid,
    output logic                s_rready,
    input  logic [DATA_W-1:0]   s_rdata,
    input  logic [1:0]          s_rresp
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t              r_state;
    logic                r_grant;
    logic                r_last_grant;
    logic                r_s_arvalid;
    logic [ADDR_W-1:0]   r_s_araddr;

    logic [1:0]          w_arb;
    logic                w_gnt;
    logic [ADDR_W-1:0]   w_addr;
    logic [1:0]          w_rsel;

    // One-hot arbitration; on a tie the master not served last wins.
    always_comb begin
        w_arb = 2'b00;
        case (m_arvalid)
            2'b01:   w_arb = 2'b01;
            2'b10:   w_arb = 2'b10;
            2'b11:   w_arb = r_last_grant ? 2'b01 : 2'b10;
            default: w_arb = 2'b00;
        endcase
    end

    assign w_gnt  = w_arb[1];
    assign w_addr = w_gnt ? m_araddr[ADDR_W +: ADDR_W] : m_araddr[0 +: ADDR_W];

    // rst_n gating keeps the combinational ready low while reset is held.
    assign m_arready = (rst_n && (r_state == ST_IDLE)) ? w_arb : 2'b00;

    assign w_rsel    = (r_state == ST_RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
    assign m_rvalid  = w_rsel & {2{s_rvalid}};
    assign s_rready  = |(w_rsel & m_rready);
    assign s_arvalid = r_s_arvalid;
    assign s_araddr  = r_s_araddr;

    generate
        for (genvar i = 0; i < 2; i++) begin : g_rslice
            assign m_rdata[i*DATA_W +: DATA_W] = w_rsel[i] ? s_rdata : '0;
            assign m_rresp[2*i +: 2]           = w_rsel[i] ? s_rresp : 2'b00;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_s_arvalid  <= 1'b0;
            r_s_araddr   <= '0;
            r_grant      <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|m_arvalid) begin
                        r_state     <= ST_ADDR;
                        r_s_arvalid <= 1'b1;
                        r_s_araddr  <= w_addr;
                        r_grant     <= w_gnt;
                    end
                end
                ST_ADDR: begin
                    if (s_arready) begin
                        r_state     <= ST_RESP;
                        r_s_arvalid <= 1'b0;
                    end
                end
                ST_RESP: begin
                    if (s_rvalid && s_rready) begin
                        r_state      <= ST_IDLE;
                        r_last_grant <= r_grant;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_s_arvalid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/axi_lite_rd_arbiter.md
AXI_LITE_RD_ARBITER -- requirements
Module: axi_lite_rd_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the AXI-lite read address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the AXI-lite read data width.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 The block SHALL have port m_arvalid, input, 2, per-master AR valid; bit 0 is IFU, bit 1 is LSU.
REQ-006 The block SHALL have port m_arready, output, 2, per-master AR ready.
REQ-007 The block SHALL have port m_araddr, input, 2*ADDR_W, per-master address; master i uses slice [i*ADDR_W +: ADDR_W].
REQ-008 The block SHALL have port m_rvalid, output, 2, per-master R valid.
REQ-009 The block SHALL have port m_rready, input, 2, per-master R ready.
REQ-010 The block SHALL have port m_rdata, output, 2*DATA_W, per-master read data, sliced as in REQ-007.
REQ-011 The block SHALL have port m_rresp, output, 4, per-master RRESP; master i uses slice [2i+1:2i].
REQ-012 The block SHALL have port s_arvalid, output, 1, slave AR valid.
REQ-013 The block SHALL have port s_arready, input, 1, slave AR ready.
REQ-014 The block SHALL have port s_araddr, output, ADDR_W, slave address.
REQ-015 The block SHALL have port s_rvalid, input, 1, slave R valid.
REQ-016 The block SHALL have port s_rready, output, 1, slave R ready.
REQ-017 The block SHALL have port s_rdata, input, DATA_W, slave read data.
REQ-018 The block SHALL have port s_rresp, input, 2, slave RRESP.

Function
REQ-019 The block SHALL implement a three-state FSM: IDLE (no transaction), ADDR (s_arvalid high, waiting on s_arready), and RESP (waiting on the slave R handshake).
REQ-020 The block SHALL track at most one outstanding transaction and SHALL hold m_arready at 0 for both masters outside IDLE.
REQ-021 In IDLE with m_arvalid != 0, the block SHALL select grant g combinationally, assert m_arready[g]=1 and m_arready[!g]=0 in that cycle, latch m_araddr slice g into s_araddr, latch g, and go to ADDR on the next edge.
REQ-022 Selection SHALL be round-robin: if only one master is valid, that master wins; if both are valid, the master != last_grant wins.
REQ-023 last_grant SHALL be updated to g only on completion of the R handshake.
REQ-024 In ADDR, the block SHALL hold s_arvalid=1 with s_araddr stable, and SHALL go to RESP on the edge where s_arvalid&&s_arready.
REQ-025 s_arvalid SHALL be 1 only in ADDR.
REQ-026 In RESP, the block SHALL drive m_rvalid[g]=s_rvalid, s_rready=m_rready[g], and m_rdata/m_rresp slice g = s_rdata/s_rresp.
REQ-027 In RESP, m_rvalid[!g] SHALL be 0.
REQ-028 On s_rvalid&&s_rready in RESP, the block SHALL return to IDLE on the next edge; a new grant is possible in that IDLE cycle.
REQ-029 Outside RESP, m_rvalid SHALL be 2'b00 and s_rready SHALL be 0.
REQ-030 Non-granted data slices SHALL be driven 0.
REQ-031 A master deasserting m_arvalid after its AR handshake SHALL have no effect; the latched address is used.
REQ-032 s_rresp SLVERR/DECERR SHALL pass through unchanged, with no retry.
REQ-033 Minimum latency SHALL be: master AR handshake at cycle N, s_arvalid at N+1, and earliest m_rvalid at N+2 (slave with arready=1 and rvalid=1 immediately).
REQ-034 The states SHALL be encoded in 2 bits; the unreachable code SHALL return to IDLE.

Reset
REQ-035 rst_n=0 SHALL asynchronously force: state=IDLE, s_arvalid=0, s_araddr=0, latched grant=0, last_grant=1 (IFU wins the first tie), and s_rready=0, m_rvalid=0, m_arready=0.
REQ-036 Reset mid-transaction SHALL abandon that transaction with no response delivered; after reset release, the block SHALL start in IDLE.

Verification
REQ-037 Single IFU read: m_arvalid=01, addr 0x80000000, slave zero-wait -> m_arready=01 in cycle 0, s_arvalid=1 with addr 0x80000000 in cycle 1, m_rvalid=01 with slave data in cycle 2.
REQ-038 Simultaneous requests after reset: m_arvalid=11 held -> grants IFU, LSU, IFU, LSU in strict alternation, and never both m_arready bits set.
REQ-039 Slave backpressure: s_arready low 5 cycles -> s_arvalid held for 6 cycles, s_araddr constant, m_arready=00 throughout.
REQ-040 Master R stall: m_rready[g]=0 for 3 cycles with s_rvalid=1 -> s_rready=0 for those cycles, data held, single completion.
REQ-041 Error pass-through: s_rresp=2'b10 to the LSU -> m_rresp[3:2]=2'b10 and m_rresp[1:0]=0.
REQ-042 Async reset asserted in RESP -> s_rready, m_rvalid, and s_arvalid drop to 0 without a clock edge, and the next request after release is granted to IFU on a tie.
